// File: rtl/fifo_arb_pkg.sv
// Shared types, width helpers and the packed-bus slice helper for the
// FIFO write-port arbiter and its priority picker.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index width for a field that must hold values 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BURST_LEN  = 4;
    localparam int DEF_GRANT_W    = idx_width(DEF_NUM_REQ);
    localparam int DEF_CNT_W      = idx_width(DEF_BURST_LEN);

    // Bit offset of word 'idx' inside a bus of packed 'width'-bit words.
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: returns the first set request at or
// above rr_ptr, wrapping modulo NUM_REQ. Shared by read- and write-side schedulers.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    // Candidate index rr_ptr+offset folded back into 0..NUM_REQ-1.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int offset);
        int sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_W'(sum);
    endfunction

    // Scan from the farthest candidate to the nearest so the nearest set request wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        winner  = rr_ptr;
        any_req = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[wrap_add(rr_ptr, k)]) begin
                winner = wrap_add(rr_ptr, k);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ producers.
// A grant lasts up to BURST_LEN accepted beats; every release passes through
// one IDLE cycle. Beats are never issued while the FIFO reports full.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int BURST_LEN  = DEF_BURST_LEN,
    localparam int GRANT_W    = idx_width(NUM_REQ),
    localparam int CNT_W      = idx_width(BURST_LEN)
) (
    input  logic                          clk,
    input  logic                          w_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [GRANT_W-1:0]            grant_id,
    output logic                          busy
);

    arb_state_e         state_q, state_d;
    logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [GRANT_W-1:0] winner;
    logic               any_req;
    logic               grant_valid;
    logic               beat;
    logic               last_beat;
    logic [GRANT_W-1:0] next_ptr;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    assign busy        = (state_q == GRANT);
    assign grant_valid = req_valid[grant_q];
    assign beat        = busy & grant_valid & ~full;
    assign last_beat   = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
    assign next_ptr    = (grant_q == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    assign w_en        = beat;
    assign grant_id    = grant_q;

    // One-hot accept strobe to the grantee, only on a beat.
    always_comb begin
        req_ready = '0;
        if (beat) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    // Route the grantee's word to the FIFO; drive zero outside GRANT.
    always_comb begin
        data_in = '0;
        if (busy) begin
            data_in = req_data[slice_lsb(int'(grant_q), DATA_WIDTH) +: DATA_WIDTH];
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d    = GRANT;
                    grant_d    = winner;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!grant_valid) begin
                    // Grantee went quiet: give the port up early.
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end else if (!full) begin
                    if (last_beat) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
                // full with valid held: stall, nothing changes.
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge w_rst) begin
        if (!w_rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: producer queues feed the
// arbiter, and a transaction-level model (owner / beats-taken / pointer)
// predicts every output each cycle. Directed scenarios then random traffic.
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;
    localparam int GW = 2;

    logic            clk = 1'b0;
    logic            w_rst = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            full;
    logic            w_en;
    logic [DW-1:0]   data_in;
    logic [GW-1:0]   grant_id;
    logic            busy;

    fifo_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk       (clk),
        .w_rst     (w_rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .w_en      (w_en),
        .data_in   (data_in),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Producer queues and stimulus knobs
    logic [7:0] q [N][$];
    bit         en [N];
    bit         full_v;

    // Reference model: who owns the port (-1 = nobody), beats taken so far,
    // where the next search starts, and the last grantee.
    int m_owner, m_beats, m_ptr, m_gid;

    // Observation logs for directed checks
    logic [7:0] wlog[$];
    int         wcyc[$];
    int         glog[$];
    int         gcyc[$];
    bit         prev_busy;
    int         cyc;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_ptr   = 0;
        m_gid   = 0;
    endtask

    task automatic clear_logs();
        wlog.delete(); wcyc.delete(); glog.delete(); gcyc.delete();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (q[i].size() > 0) && en[i];
            req_data[i*DW +: DW] = (q[i].size() > 0) ? q[i][0] : 8'($urandom);
        end
        full = full_v;
    endtask

    task automatic compare_outputs();
        logic [GW-1:0] oi;
        bit            exp_busy, exp_beat;
        logic [N-1:0]  exp_ready;
        logic [DW-1:0] exp_data;
        oi        = GW'((m_owner < 0) ? 0 : m_owner);
        exp_busy  = (m_owner >= 0);
        exp_beat  = exp_busy && req_valid[oi] && !full;
        exp_ready = exp_beat ? (N'(1) << oi) : '0;
        exp_data  = exp_busy ? req_data[oi*DW +: DW] : '0;
        check("busy",      32'(busy),      32'(exp_busy));
        check("w_en",      32'(w_en),      32'(exp_beat));
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("data_in",   32'(data_in),   32'(exp_data));
        check("grant_id",  32'(grant_id),  32'(m_gid));
        if (w_en) begin
            wlog.push_back(data_in);
            wcyc.push_back(cyc);
        end
        if (busy && !prev_busy) begin
            glog.push_back(int'(grant_id));
            gcyc.push_back(cyc);
        end
        prev_busy = busy;
    endtask

    task automatic advance_model();
        if (!w_rst) return;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int idx = (m_ptr + k) % N;
                if (m_owner < 0 && req_valid[GW'(idx)]) begin
                    m_owner = idx;
                    m_beats = 0;
                    m_gid   = idx;
                end
            end
        end else if (!req_valid[GW'(m_owner)]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (!full) begin
            void'(q[m_owner].pop_front());
            m_beats++;
            if (m_beats == BL) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    // One clock: drive just after the edge, compare at the falling edge, step model at the edge.
    task automatic cycle();
        drive_inputs();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        advance_model();
        cyc++;
        #1;
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n = 0;
        while ((!all_empty() || m_owner >= 0) && n < max_cycles) begin
            cycle();
            n++;
        end
        check("drain_timeout", 32'(n >= max_cycles), 0);
        cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0;
        prev_busy = 1'b0;
        full_v = 1'b0;
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        model_reset();

        // Reset held with every requester valid: outputs stay quiet.
        for (int i = 0; i < N; i++) q[i].push_back(8'(8'hA0 + i));
        drive_inputs();
        #1;
        check("rst_w_en",      32'(w_en),      0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_data_in",   32'(data_in),   0);
        @(posedge clk); #1;
        cycle();
        cycle();
        clear_logs();
        w_rst = 1'b1;
        run_until_idle(100);
        check("rst_grant_cnt", 32'(glog.size()), 4);
        for (int k = 0; k < glog.size() && k < 4; k++) check("rst_grant_order", 32'(glog[k]), 32'(k));

        // All four requesters streaming: grants 0,1,2,3,0 spaced 5 cycles apart.
        clear_logs();
        for (int i = 0; i < N; i++)
            for (int w = 0; w < 8; w++) q[i].push_back(8'($urandom));
        run_until_idle(200);
        check("rr_grant_cnt", 32'(glog.size()), 8);
        for (int k = 0; k < 5 && k < glog.size(); k++) check("rr_grant_order", 32'(glog[k]), 32'(k % N));
        for (int k = 0; k < 4 && k + 1 < gcyc.size(); k++) check("rr_grant_spacing", 32'(gcyc[k+1] - gcyc[k]), 5);

        // Single requester 1 with six words: 4-beat burst, one IDLE, then 2 beats.
        clear_logs();
        for (int w = 0; w < 6; w++) q[1].push_back(8'(8'h10 + w));
        run_until_idle(100);
        check("single_writes", 32'(wlog.size()), 6);
        for (int k = 0; k < 6 && k < wlog.size(); k++) check("single_data", 32'(wlog[k]), 32'(8'h10 + k));
        if (wcyc.size() >= 5) check("single_regrant_gap", 32'(wcyc[4] - wcyc[3]), 2);
        check("single_grants", 32'(glog.size()), 2);
        for (int k = 0; k < glog.size(); k++) check("single_grant_id", 32'(glog[k]), 1);

        // Requester 2 stalls three cycles on full after its second beat.
        clear_logs();
        for (int w = 0; w < 4; w++) q[2].push_back(8'(8'h20 + w));
        cycle();
        cycle();
        cycle();
        full_v = 1'b1;
        repeat (3) cycle();
        full_v = 1'b0;
        run_until_idle(100);
        check("stall_writes", 32'(wlog.size()), 4);
        for (int k = 0; k < 4 && k < wlog.size(); k++) check("stall_data", 32'(wlog[k]), 32'(8'h20 + k));
        if (wcyc.size() >= 3) check("stall_gap", 32'(wcyc[2] - wcyc[1]), 4);
        check("stall_grants", 32'(glog.size()), 1);

        // Asynchronous reset between edges in the middle of a burst.
        for (int i = 0; i < N; i++)
            for (int w = 0; w < 4; w++) q[i].push_back(8'($urandom));
        cycle();
        cycle();
        cycle();
        drive_inputs();
        #1;
        check("pre_reset_w_en", 32'(w_en), 1);
        w_rst = 1'b0;
        #1;
        check("async_rst_w_en",      32'(w_en),      0);
        check("async_rst_req_ready", 32'(req_ready), 0);
        check("async_rst_busy",      32'(busy),      0);
        check("async_rst_grant_id",  32'(grant_id),  0);
        model_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        @(posedge clk);
        cyc++;
        #1;
        cycle();
        w_rst = 1'b1;

        // Requester 0 leaves after two beats while 1 and 3 wait: order 0,1,3.
        clear_logs();
        for (int w = 0; w < 2; w++) q[0].push_back(8'(8'h40 + w));
        for (int w = 0; w < 4; w++) q[1].push_back(8'(8'h50 + w));
        for (int w = 0; w < 4; w++) q[3].push_back(8'(8'h70 + w));
        run_until_idle(100);
        check("early_grant_cnt", 32'(glog.size()), 3);
        if (glog.size() == 3) begin
            check("early_grant_0", 32'(glog[0]), 0);
            check("early_grant_1", 32'(glog[1]), 1);
            check("early_grant_2", 32'(glog[2]), 3);
        end
        check("early_writes", 32'(wlog.size()), 10);

        // Random traffic with gated valids and a random full flag.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(2) == 0 && q[i].size() < 16) q[i].push_back(8'($urandom));
                en[i] = ($urandom_range(7) != 0);
            end
            full_v = ($urandom_range(3) == 0);
            cycle();
        end
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        full_v = 1'b0;
        run_until_idle(500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
